// File: rtl/fadd_share_arbiter_pkg.sv
// Shared definitions for the FP-adder sharing arbiter and its clients.
//   - FP_W / RM_W      : operand and round-mode widths
//   - state_t          : arbiter FSM encoding
//   - RM_*             : round-mode encodings understood by floating_point_adder
//   - fadd_op_t        : one registered add/sub request
package fadd_share_arbiter_pkg;

    localparam int FP_W = 32;
    localparam int RM_W = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [RM_W-1:0] RM_RNE = 2'd0;  // nearest, ties to even
    localparam logic [RM_W-1:0] RM_RTZ = 2'd1;  // toward zero
    localparam logic [RM_W-1:0] RM_RUP = 2'd2;  // toward +inf
    localparam logic [RM_W-1:0] RM_RDN = 2'd3;  // toward -inf

    typedef struct packed {
        logic            sub;
        logic [FP_W-1:0] a;
        logic [FP_W-1:0] b;
        logic [RM_W-1:0] rm;
    } fadd_op_t;

endpackage

// File: rtl/fadd_share_arbiter_if.sv
// Request/response bundle between NUM_REQ FP clients and the shared adder arbiter.
//   req_valid/req_ready      : per-requester request handshake (ready is one-hot or zero)
//   req_sub/req_a/req_b/req_rm: per-requester operation, packed slice i = requester i
//   resp_valid/resp_ready    : per-requester response handshake (valid is one-hot or zero)
//   resp_s                   : result word, shared by all requesters
// master = client side, slave = arbiter side.
interface fadd_share_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import fadd_share_arbiter_pkg::*;

    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ-1:0]      req_sub;
    logic [FP_W*NUM_REQ-1:0] req_a;
    logic [FP_W*NUM_REQ-1:0] req_b;
    logic [RM_W*NUM_REQ-1:0] req_rm;
    logic [NUM_REQ-1:0]      resp_valid;
    logic [NUM_REQ-1:0]      resp_ready;
    logic [FP_W-1:0]         resp_s;

    modport master (
        output req_valid, req_sub, req_a, req_b, req_rm, resp_ready,
        input  req_ready, resp_valid, resp_s
    );

    modport slave (
        input  req_valid, req_sub, req_a, req_b, req_rm, resp_ready,
        output req_ready, resp_valid, resp_s
    );

endinterface

// File: rtl/fadd_share_arbiter_fpadd.sv
// floating_point_adder: purely combinational IEEE-754 single-precision add/sub.
//   sub        : 1 = a - b, 0 = a + b
//   a, b       : operands
//   round_mode : RM_RNE / RM_RTZ / RM_RUP / RM_RDN
//   s          : result (any NaN input or inf-inf gives canonical quiet NaN)
// Subnormals are handled on both input and output.
module floating_point_adder
    import fadd_share_arbiter_pkg::*;
(
    input  logic            sub,
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    input  logic [RM_W-1:0] round_mode,
    output logic [FP_W-1:0] s
);

    function automatic logic [4:0] clz27(input logic [26:0] v);
        clz27 = 5'd27;
        for (int i = 0; i < 27; i++)
            if (v[i]) clz27 = 5'(26 - i);
    endfunction

    logic        sa, sb, sx, sy, eff_sub, inc, inexact;
    logic [7:0]  ea, eb, ex, ey, d;
    logic [23:0] ma, mb, mx, my, mant24, mant;
    logic [26:0] mx27, my27, my_al, norm;
    logic [27:0] sum28;
    logic [24:0] rnd;
    logic [9:0]  e, sh, lim;
    logic [4:0]  lz;
    logic        a_nan, b_nan, a_inf, b_inf;

    always_comb begin
        sa    = a[31];
        sb    = b[31] ^ sub;
        a_nan = (&a[30:23]) && (|a[22:0]);
        b_nan = (&b[30:23]) && (|b[22:0]);
        a_inf = (&a[30:23]) && !(|a[22:0]);
        b_inf = (&b[30:23]) && !(|b[22:0]);
        // subnormals use exponent 1 with no hidden bit
        ea    = (a[30:23] == 8'd0) ? 8'd1 : a[30:23];
        eb    = (b[30:23] == 8'd0) ? 8'd1 : b[30:23];
        ma    = {|a[30:23], a[22:0]};
        mb    = {|b[30:23], b[22:0]};

        // x is the larger magnitude; raw bit order is monotonic in magnitude
        if (a[30:0] < b[30:0]) begin
            sx = sb; ex = eb; mx = mb;
            sy = sa; ey = ea; my = ma;
        end else begin
            sx = sa; ex = ea; mx = ma;
            sy = sb; ey = eb; my = mb;
        end

        // align y with 3 extra bits (guard, round, sticky)
        d    = ex - ey;
        mx27 = {mx, 3'b000};
        my27 = {my, 3'b000};
        if (d >= 8'd27) begin
            my_al = {26'd0, |my};
        end else begin
            my_al    = my27 >> d;
            my_al[0] = my_al[0] | (|(my27 & ((27'd1 << d) - 27'd1)));
        end

        eff_sub = sx ^ sy;
        sum28   = eff_sub ? ({1'b0, mx27} - {1'b0, my_al})
                          : ({1'b0, mx27} + {1'b0, my_al});

        lz   = clz27(sum28[26:0]);
        lim  = {2'b00, ex} - 10'd1;
        sh   = '0;
        if (sum28[27]) begin
            norm = {sum28[27:2], sum28[1] | sum28[0]};
            e    = {2'b00, ex} + 10'd1;
        end else begin
            // never shift below exponent 1: the result becomes subnormal instead
            sh   = ({5'd0, lz} < lim) ? {5'd0, lz} : lim;
            norm = sum28[26:0] << sh;
            e    = {2'b00, ex} - sh;
        end

        mant24  = norm[26:3];
        inexact = |norm[2:0];
        case (round_mode)
            RM_RNE:  inc = norm[2] & ((|norm[1:0]) | mant24[0]);
            RM_RUP:  inc = !sx & inexact;
            RM_RDN:  inc = sx & inexact;
            default: inc = 1'b0;
        endcase

        rnd = {1'b0, mant24} + {24'd0, inc};
        if (rnd[24]) begin
            mant = rnd[24:1];
            e    = e + 10'd1;
        end else begin
            mant = rnd[23:0];
        end

        if (sum28 == 28'd0) begin
            // exact cancellation is +0 except when rounding toward -inf
            s = {eff_sub ? (round_mode == RM_RDN) : sx, 31'd0};
        end else if (e >= 10'd255) begin
            if ((round_mode == RM_RTZ) || (round_mode == RM_RUP && sx) ||
                (round_mode == RM_RDN && !sx))
                s = {sx, 8'hFE, 23'h7FFFFF};
            else
                s = {sx, 8'hFF, 23'd0};
        end else begin
            s = {sx, mant[23] ? e[7:0] : 8'd0, mant[22:0]};
        end

        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb)))
            s = 32'h7FC0_0000;
        else if (a_inf)
            s = {sa, 8'hFF, 23'd0};
        else if (b_inf)
            s = {sb, 8'hFF, 23'd0};
    end

endmodule

// File: rtl/fadd_share_arbiter.sv
// fadd_share_arbiter: round-robin sequencer time-sharing one combinational
// floating_point_adder among NUM_REQ requesters.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of fadd_share_arbiter_if (request/response channels)
//   busy     : high while an operation is in flight (CALC or RESP)
//   op_count : completed operations, wraps modulo 2^CNT_W
// Flow: IDLE accepts the round-robin winner and registers its operands, CALC
// captures the adder output, RESP holds the result until the owner takes it.
module fadd_share_arbiter
    import fadd_share_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 16
)(
    input  logic                 clk,
    input  logic                 rst,
    fadd_share_arbiter_if.slave  bus,
    output logic                 busy,
    output logic [CNT_W-1:0]     op_count
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    state_t           state, state_nxt;
    logic [PTR_W-1:0] ptr, gnt_q, pick;
    logic             pick_vld, accept, resp_fire;
    fadd_op_t         op_q, op_sel;
    logic [FP_W-1:0]  res_q, add_s;

    // Round-robin pick: first valid bit searching ptr, ptr+1, ... modulo NUM_REQ
    always_comb begin
        int idx;
        idx      = 0;
        pick_vld = 1'b0;
        pick     = ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!pick_vld && bus.req_valid[idx]) begin
                pick_vld = 1'b1;
                pick     = PTR_W'(idx);
            end
        end
    end

    // Only the winner's slices are ever looked at
    always_comb begin
        op_sel.sub = bus.req_sub[int'(pick)];
        op_sel.a   = bus.req_a[int'(pick)*FP_W +: FP_W];
        op_sel.b   = bus.req_b[int'(pick)*FP_W +: FP_W];
        op_sel.rm  = bus.req_rm[int'(pick)*RM_W +: RM_W];
    end

    assign accept    = (state == S_IDLE) && pick_vld;
    assign resp_fire = (state == S_RESP) && bus.resp_ready[int'(gnt_q)];

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (pick_vld)  state_nxt = S_CALC;
            S_CALC:                 state_nxt = S_RESP;
            S_RESP:  if (resp_fire) state_nxt = S_IDLE;
            default:                state_nxt = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.req_ready  = accept ? (ONE << pick) : '0;
        bus.resp_valid = (state == S_RESP) ? (ONE << gnt_q) : '0;
        bus.resp_s     = res_q;
        busy           = (state == S_CALC) || (state == S_RESP);
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            gnt_q    <= '0;
            op_q     <= '0;
            res_q    <= '0;
            op_count <= '0;
        end else begin
            if (accept) begin
                op_q  <= op_sel;
                gnt_q <= pick;
                ptr   <= (int'(pick) == NUM_REQ - 1) ? '0 : pick + 1'b1;
            end
            if (state == S_CALC) res_q <= add_s;
            if (resp_fire) op_count <= op_count + 1'b1;
        end
    end

    // Adder sees only registered operands, so its inputs are stable through CALC
    floating_point_adder u_fadd (
        .sub        (op_q.sub),
        .a          (op_q.a),
        .b          (op_q.b),
        .round_mode (op_q.rm),
        .s          (add_s)
    );

endmodule
